// File: rtl/dds_gen_pkg.sv
// Shared types, widths and the amplitude clamp used by the DDS sample generator.
// The generator and its skid FIFO import everything from here.
package dds_gen_pkg;

  localparam int ACC_W      = 48;
  localparam int PHASE_W    = 16;
  localparam int AMP_W      = 14;
  localparam int PHASE_IN_W = 14;
  localparam int TS_W       = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } gen_state_t;

  // amp + sign-extended offset in a 16-bit signed sum; the sum cannot reach bit 15
  // from the positive side, so bit 15 means negative and bit 14 means above full scale.
  function automatic logic [AMP_W-1:0] amp_saturate(input logic [AMP_W-1:0] amp,
                                                    input logic [AMP_W-1:0] amp_offset);
    logic signed [AMP_W+1:0] sum;
    sum = signed'({2'b00, amp}) + signed'({{2{amp_offset[AMP_W-1]}}, amp_offset});
    if (sum[AMP_W+1]) begin
      return '0;
    end else if (sum[AMP_W]) begin
      return '1;
    end else begin
      return sum[AMP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dds_skid_fifo.sv
// Two-entry synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module dds_skid_fifo
  import dds_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [WIDTH-1:0] data;
    always_ff @(posedge clk) begin
      if (reset) begin
        data <= '0;
      end else if (do_push && (wr_ptr == 1'(gi))) begin
        data <= push_data;
      end
    end
  end

  assign head = rd_ptr ? g_entry[1].data : g_entry[0].data;

endmodule

// File: rtl/dds_sample_gen.sv
// Timestamp-aligned phase accumulator emitting one phase/amplitude word per cycle;
// backpressure beyond the 2-entry skid FIFO drops samples instead of stalling time.
module dds_sample_gen
  import dds_gen_pkg::*;
#(
  parameter int ACC_WIDTH       = ACC_W,
  parameter int PHASE_OUT_WIDTH = PHASE_W,
  parameter int AMP_WIDTH       = AMP_W,
  parameter int DROP_CNT_WIDTH  = 16
) (
  input  logic                                  CLK100MHZ,
  input  logic                                  reset,
  input  logic                                  run_en,
  input  logic [ACC_WIDTH-1:0]                  freq,
  input  logic [AMP_WIDTH-1:0]                  amp,
  input  logic [PHASE_IN_W-1:0]                 phase,
  input  logic [AMP_WIDTH-1:0]                  amp_offset,
  input  logic [TS_W-1:0]                       time_offset,
  input  logic [TS_W-1:0]                       timestamp,
  output logic [AMP_WIDTH+PHASE_OUT_WIDTH+1:0]  m_tdata,
  output logic                                  m_tvalid,
  input  logic                                  m_tready,
  output logic [1:0]                            state,
  output logic                                  overflow,
  output logic [DROP_CNT_WIDTH-1:0]             drop_count
);

  localparam int DATA_W = AMP_WIDTH + PHASE_OUT_WIDTH + 2;

  gen_state_t                 cur_state;
  gen_state_t                 next_state;
  logic [ACC_WIDTH-1:0]       acc;
  logic [ACC_WIDTH-1:0]       acc_next;
  logic [TS_W-1:0]            t_ref;
  logic [PHASE_OUT_WIDTH-1:0] phase_word;
  logic                       s1_valid;
  logic [DATA_W-1:0]          s1_data;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;
  logic                       drop;

  always_comb begin
    next_state = cur_state;
    acc_next   = acc;
    case (cur_state)
      IDLE: begin
        acc_next = '0;
        if (run_en) next_state = ARMED;
      end
      ARMED: begin
        if (timestamp >= time_offset) begin
          next_state = RUN;
          acc_next   = '0;
        end
      end
      RUN: begin
        // A moved alignment target re-arms with the phase frozen until the new match.
        if (time_offset != t_ref) next_state = ARMED;
        else                      acc_next   = acc + freq;
      end
      default: begin
        next_state = IDLE;
        acc_next   = '0;
      end
    endcase
    if (!run_en) begin
      next_state = IDLE;
      acc_next   = '0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      cur_state <= IDLE;
      acc       <= '0;
      t_ref     <= '0;
    end else begin
      cur_state <= next_state;
      acc       <= acc_next;
      if (cur_state == ARMED) t_ref <= time_offset;
    end
  end

  assign phase_word = acc[ACC_WIDTH-1 -: PHASE_OUT_WIDTH]
                    + {phase, {(PHASE_OUT_WIDTH-PHASE_IN_W){1'b0}}};

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= (cur_state == RUN);
      s1_data  <= {2'b00, amp_saturate(amp, amp_offset), phase_word};
    end
  end

  assign pop      = m_tvalid && m_tready;
  assign m_tvalid = !fifo_empty;
  assign drop     = s1_valid && fifo_full && !pop;
  assign state    = cur_state;

  dds_skid_fifo #(
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (CLK100MHZ),
    .reset     (reset),
    .push      (s1_valid),
    .push_data (s1_data),
    .pop       (pop),
    .head      (m_tdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
    end
  end

endmodule
